// File: rtl/arbiter_client.sv
// Requester-side companion to a fixed-priority arbiter: per-channel pending
// counters, registered burst ownership, and a sticky grant-protocol error flag.
module arbiter_client #(
  parameter int N  = 16,
  parameter int CW = 4,
  parameter int BW = 4
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [N-1:0]  push,
  input  logic [BW-1:0] burst,
  output logic [N-1:0]  request,
  input  logic [N-1:0]  grant,
  output logic [N-1:0]  active,
  output logic [N-1:0]  done,
  output logic [N-1:0]  pending_full,
  output logic          error
);

  localparam logic [CW-1:0] PEND_MAX = '1;

  logic [BW-1:0] cnt_q;
  logic          idle;
  logic          last;
  logic          win_open;
  logic          grant_onehot;
  logic          grant_legal;
  logic          accept;
  logic          violation;

  assign idle     = (active == '0);
  assign last     = !idle && (cnt_q == '0);
  assign win_open = idle || last;
  assign done     = active & {N{last}};

  // A grant is only legal for a single channel that is currently requesting;
  // request is already gated by win_open, so a grant while busy is illegal too.
  assign grant_onehot = (grant != '0) && ((grant & (grant - N'(1))) == '0);
  assign grant_legal  = ((grant & ~request) == '0);
  assign accept       = grant_onehot && grant_legal && win_open;
  assign violation    = (grant != '0) && !(grant_onehot && grant_legal);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      active <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      active <= grant;
      cnt_q  <= burst;
    end else if (last) begin
      active <= '0;
    end else if (!idle) begin
      cnt_q <= cnt_q - BW'(1);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      error <= 1'b0;
    end else if (violation) begin
      error <= 1'b1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    logic [CW-1:0] pending_q;
    logic          inc;
    logic          dec;

    assign inc             = push[i] && !pending_full[i];
    assign dec             = accept && grant[i];
    assign request[i]      = (pending_q != '0) && win_open;
    assign pending_full[i] = (pending_q == PEND_MAX);

    // NOTE: the pending counters are flops, not RAM, so they take the async
    // reset like all other state; queued work must vanish on nreset.
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        pending_q <= '0;
      end else if (inc && !dec) begin
        pending_q <= pending_q + CW'(1);
      end else if (dec && !inc) begin
        pending_q <= pending_q - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_arbiter_client.sv
// Directed bench for arbiter_client: expected per-cycle outputs are queued as
// stimulus is driven and popped/compared one time unit after each clock edge.
module tb_arbiter_client;

  localparam int N  = 16;
  localparam int CW = 4;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          nreset;
  logic [N-1:0]  push;
  logic [BW-1:0] burst;
  logic [N-1:0]  request;
  logic [N-1:0]  grant;
  logic [N-1:0]  active;
  logic [N-1:0]  done;
  logic [N-1:0]  pending_full;
  logic          error;

  // Bench-side arbiter: fixed priority (lowest index) or a forced override.
  logic          arb_en;
  logic [N-1:0]  grant_ovr;
  assign grant = arb_en ? (request & (~request + N'(1))) : grant_ovr;

  arbiter_client #(.N(N), .CW(CW), .BW(BW)) dut (
    .clk          (clk),
    .nreset       (nreset),
    .push         (push),
    .burst        (burst),
    .request      (request),
    .grant        (grant),
    .active       (active),
    .done         (done),
    .pending_full (pending_full),
    .error        (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [N-1:0] req;
    logic [N-1:0] act;
    logic [N-1:0] dn;
    logic [N-1:0] pf;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic sb_push(input string tag, input logic [N-1:0] req,
                         input logic [N-1:0] act, input logic [N-1:0] dn,
                         input logic [N-1:0] pf, input logic err);
    exp_t e;
    e.tag = tag; e.req = req; e.act = act; e.dn = dn; e.pf = pf; e.err = err;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input logic [N-1:0] got, input logic [N-1:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty got=0 want=1");
    end else begin
      e = sb.pop_front();
      cmp({e.tag, ".request"}, request, e.req);
      cmp({e.tag, ".active"}, active, e.act);
      cmp({e.tag, ".done"}, done, e.dn);
      cmp({e.tag, ".pending_full"}, pending_full, e.pf);
      cmp({e.tag, ".error"}, {{(N-1){1'b0}}, error}, {{(N-1){1'b0}}, e.err});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nreset    = 1'b0;
    push      = '0;
    burst     = '0;
    arb_en    = 1'b1;
    grant_ovr = '0;

    // Reset state
    #1;
    sb_push("reset", '0, '0, '0, '0, 1'b0);
    sb_check();
    tick();
    tick();
    nreset = 1'b1;
    tick();

    // Single push on ch3, burst=2: three owned cycles, done in the third
    burst = 4'd2;
    push  = 16'h0008;
    sb_push("t1_req", 16'h0008, '0, '0, '0, 1'b0);
    tick(); push = '0; sb_check();
    sb_push("t1_own0", '0, 16'h0008, '0, '0, 1'b0);
    tick(); sb_check();
    sb_push("t1_own1", '0, 16'h0008, '0, '0, 1'b0);
    tick(); sb_check();
    sb_push("t1_own2", '0, 16'h0008, 16'h0008, '0, 1'b0);
    tick(); sb_check();
    sb_push("t1_idle", '0, '0, '0, '0, 1'b0);
    tick(); sb_check();

    // ch1 and ch5 together, burst=0: back-to-back ownership, no bubble
    burst = 4'd0;
    push  = 16'h0022;
    sb_push("t2_req", 16'h0022, '0, '0, '0, 1'b0);
    tick(); push = '0; sb_check();
    sb_push("t2_ch1", 16'h0020, 16'h0002, 16'h0002, '0, 1'b0);
    tick(); sb_check();
    sb_push("t2_ch5", '0, 16'h0020, 16'h0020, '0, 1'b0);
    tick(); sb_check();
    sb_push("t2_idle", '0, '0, '0, '0, 1'b0);
    tick(); sb_check();

    // Saturate ch0 with grants held off; the 16th push is dropped
    arb_en    = 1'b0;
    grant_ovr = '0;
    push      = 16'h0001;
    for (int i = 1; i <= 16; i++) begin
      sb_push($sformatf("t3_fill%0d", i), 16'h0001, '0, '0,
              (i >= 15) ? 16'h0001 : 16'h0000, 1'b0);
      tick(); sb_check();
    end
    push   = '0;
    arb_en = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      sb_push($sformatf("t3_drain%0d", k), (k < 15) ? 16'h0001 : 16'h0000,
              16'h0001, 16'h0001, '0, 1'b0);
      tick(); sb_check();
    end
    sb_push("t3_idle", '0, '0, '0, '0, 1'b0);
    tick(); sb_check();

    // Push on ch2 in its own accept cycle: pending unchanged, second burst follows
    push = 16'h0004;
    sb_push("t5_req", 16'h0004, '0, '0, '0, 1'b0);
    tick(); sb_check();
    sb_push("t5_own0", 16'h0004, 16'h0004, 16'h0004, '0, 1'b0);
    tick(); push = '0; sb_check();
    sb_push("t5_own1", '0, 16'h0004, 16'h0004, '0, 1'b0);
    tick(); sb_check();
    sb_push("t5_idle", '0, '0, '0, '0, 1'b0);
    tick(); sb_check();

    // Non-one-hot grant while ch0/ch1 request: sticky error, no ownership
    arb_en    = 1'b0;
    grant_ovr = '0;
    push      = 16'h0003;
    sb_push("t4_req", 16'h0003, '0, '0, '0, 1'b0);
    tick(); push = '0; sb_check();
    sb_push("t4_zero_grant", 16'h0003, '0, '0, '0, 1'b0);
    tick(); sb_check();
    grant_ovr = 16'h0003;
    sb_push("t4_multi", 16'h0003, '0, '0, '0, 1'b1);
    tick(); grant_ovr = '0; sb_check();
    sb_push("t4_sticky", 16'h0003, '0, '0, '0, 1'b1);
    tick(); sb_check();
    nreset = 1'b0;
    #1;
    sb_push("t4_rst", '0, '0, '0, '0, 1'b0);
    sb_check();
    tick();
    nreset = 1'b1;

    // Grant to a channel that is not requesting
    grant_ovr = 16'h0010;
    sb_push("t4_unreq", '0, '0, '0, '0, 1'b1);
    tick(); grant_ovr = '0; sb_check();
    sb_push("t4_unreq_sticky", '0, '0, '0, '0, 1'b1);
    tick(); sb_check();
    nreset = 1'b0;
    #1;
    sb_push("t4_rst2", '0, '0, '0, '0, 1'b0);
    sb_check();
    tick();
    nreset = 1'b1;

    // Mid-burst on ch6 with a busy-time grant violation, then async reset
    arb_en = 1'b1;
    burst  = 4'd5;
    push   = 16'h0040;
    sb_push("t6_req", 16'h0040, '0, '0, '0, 1'b0);
    tick(); push = '0; sb_check();
    sb_push("t6_own0", '0, 16'h0040, '0, '0, 1'b0);
    tick(); sb_check();
    arb_en    = 1'b0;
    grant_ovr = 16'h0040;
    sb_push("t6_busy_grant", '0, 16'h0040, '0, '0, 1'b1);
    tick(); grant_ovr = '0; sb_check();
    sb_push("t6_own2", '0, 16'h0040, '0, '0, 1'b1);
    tick(); sb_check();
    #2;
    nreset = 1'b0;
    #1;
    sb_push("t6_async_rst", '0, '0, '0, '0, 1'b0);
    sb_check();
    tick();
    nreset = 1'b1;
    arb_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sb_push($sformatf("t6_quiet%0d", k), '0, '0, '0, '0, 1'b0);
      tick(); sb_check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
